// File: rtl/game_pkg.sv
// Shared definitions for the quiz-game round controller: FSM states, mode codes, default timings.
// Build option: define SCORE_BCD_EN for a two-digit BCD score; otherwise the score is binary.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ANS,
    S_JUDGE,
    S_SHOW,
    S_PAUSE,
    S_OVER
  } state_t;

  localparam logic [1:0] MODE_EASY   = 2'b00;
  localparam logic [1:0] MODE_NORM   = 2'b01;
  localparam logic [1:0] MODE_HARD   = 2'b10;
  localparam logic [1:0] MODE_SUDDEN = 2'b11;

  localparam int LIVES_DEF    = 3;
  localparam int TICK_DIV_DEF = 100_000_000;
  localparam int T_EASY_DEF   = 10;
  localparam int T_NORM_DEF   = 6;
  localparam int T_HARD_DEF   = 3;
  localparam int FEEDBACK_DEF = 1;

  // Saturating +1 on the displayed score.
  function automatic logic [7:0] score_inc(input logic [7:0] s);
`ifdef SCORE_BCD_EN
    if (s == 8'h99) return s;
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
`else
    if (s == 8'hFF) return s;
    return s + 8'd1;
`endif
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts enabled cycles and emits a one-cycle tick every TICK_DIV of them.
// clear restarts the count; a disabled prescaler holds its value.
module sec_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else if (enable)    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round/lives controller for the keyboard quiz game: problem fetch, per-question countdown,
// judging, lives/score bookkeeping and pause. Score format selected by SCORE_BCD_EN.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int LIVES        = LIVES_DEF,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int T_EASY       = T_EASY_DEF,
  parameter int T_NORM       = T_NORM_DEF,
  parameter int T_HARD       = T_HARD_DEF,
  parameter int FEEDBACK_SEC = FEEDBACK_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic [1:0] mode,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       prob_req,
  input  logic       prob_ack,
  input  logic [3:0] prob_answer,
  output logic [2:0] life,
  output logic       right,
  output logic       wrong,
  output logic       game_over,
  output logic [7:0] score,
  output logic [3:0] time_left,
  output logic       playing,
  output logic       paused
);

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [3:0] TL_EASY    = 4'(T_EASY);
  localparam logic [3:0] TL_NORM    = 4'(T_NORM);
  localparam logic [3:0] TL_HARD    = 4'(T_HARD);
  localparam logic [7:0] FB_LAST    = 8'(FEEDBACK_SEC - 1);

  state_t     state;
  logic       ss_q;
  logic       ss_edge;
  logic [1:0] mode_q;
  logic [3:0] answer;
  logic [3:0] key_q;
  logic       timed_out;
  logic [7:0] fb_cnt;
  logic       tick;
  logic       tick_en;
  logic       tick_clr;

  function automatic logic [3:0] q_time(input logic [1:0] m);
    case (m)
      MODE_EASY:              return TL_EASY;
      MODE_NORM:              return TL_NORM;
      MODE_HARD, MODE_SUDDEN: return TL_HARD;
      default:                return TL_HARD;
    endcase
  endfunction

  assign ss_edge  = start_stop & ~ss_q;
  assign tick_en  = (state == S_WAIT_ANS) || (state == S_SHOW);
  assign tick_clr = (state == S_REQ) && prob_ack;

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (tick_clr),
    .enable (tick_en),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ss_q      <= 1'b0;
      mode_q    <= MODE_EASY;
      answer    <= '0;
      key_q     <= '0;
      timed_out <= 1'b0;
      fb_cnt    <= '0;
      prob_req  <= 1'b0;
      life      <= '0;
      right     <= 1'b0;
      wrong     <= 1'b0;
      game_over <= 1'b0;
      score     <= '0;
      time_left <= '0;
      playing   <= 1'b0;
      paused    <= 1'b0;
    end else begin
      ss_q <= start_stop;
      case (state)
        S_IDLE: if (ss_edge) begin
          life     <= (mode == MODE_SUDDEN) ? 3'd1 : LIVES_INIT;
          score    <= '0;
          mode_q   <= mode;
          playing  <= 1'b1;
          prob_req <= 1'b1;
          state    <= S_REQ;
        end
        S_REQ: if (prob_ack) begin
          answer    <= prob_answer;
          prob_req  <= 1'b0;
          time_left <= q_time(mode_q);
          state     <= S_WAIT_ANS;
        end
        // A key beats a simultaneous pause request or final tick.
        S_WAIT_ANS: begin
          if (key_valid) begin
            key_q     <= key_digit;
            timed_out <= 1'b0;
            state     <= S_JUDGE;
          end else if (ss_edge) begin
            paused <= 1'b1;
            state  <= S_PAUSE;
          end else if (tick) begin
            if (time_left <= 4'd1) begin
              time_left <= '0;
              timed_out <= 1'b1;
              state     <= S_JUDGE;
            end else begin
              time_left <= time_left - 4'd1;
            end
          end
        end
        S_JUDGE: begin
          fb_cnt <= '0;
          state  <= S_SHOW;
          if (!timed_out && key_q <= 4'd9 && key_q == answer) begin
            right <= 1'b1;
            score <= score_inc(score);
          end else begin
            wrong <= 1'b1;
            if (life != 3'd0) life <= life - 3'd1;
          end
        end
        S_SHOW: if (tick) begin
          if (fb_cnt == FB_LAST) begin
            right <= 1'b0;
            wrong <= 1'b0;
            if (life == 3'd0) begin
              game_over <= 1'b1;
              playing   <= 1'b0;
              state     <= S_OVER;
            end else begin
              prob_req <= 1'b1;
              state    <= S_REQ;
            end
          end else begin
            fb_cnt <= fb_cnt + 8'd1;
          end
        end
        S_PAUSE: if (ss_edge) begin
          paused <= 1'b0;
          state  <= S_WAIT_ANS;
        end
        S_OVER: if (ss_edge) begin
          game_over <= 1'b0;
          score     <= '0;
          life      <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed-plus-random bench for game_round_ctrl; a behavioural lives/score model and a
// generator that acks two cycles after each request supply every expected value.
module tb_game_round_ctrl;

`ifdef SCORE_BCD_EN
  localparam int SCORE_MAX = 99;
`else
  localparam int SCORE_MAX = 255;
`endif

  logic       clock = 1'b0;
  logic       reset, start_stop, key_valid, prob_ack;
  logic [1:0] mode;
  logic [3:0] key_digit, prob_answer;
  logic       prob_req, right, wrong, game_over, playing, paused;
  logic [2:0] life;
  logic [7:0] score;
  logic [3:0] time_left;

  int         n_chk = 0;
  int         n_fail = 0;
  int         m_life, m_score;
  logic [3:0] gen_answer;
  int         req_age;

  always #5 clock = ~clock;

  game_round_ctrl #(
    .LIVES(3), .TICK_DIV(10), .T_EASY(10), .T_NORM(6), .T_HARD(3), .FEEDBACK_SEC(1)
  ) dut (
    .clock(clock), .reset(reset), .start_stop(start_stop), .mode(mode),
    .key_valid(key_valid), .key_digit(key_digit), .prob_req(prob_req),
    .prob_ack(prob_ack), .prob_answer(prob_answer), .life(life), .right(right),
    .wrong(wrong), .game_over(game_over), .score(score), .time_left(time_left),
    .playing(playing), .paused(paused)
  );

  // Problem generator: random answer, ack two cycles after the request is seen.
  initial begin
    prob_ack = 1'b0; prob_answer = '0; req_age = 0; gen_answer = '0;
    forever begin
      @(posedge clock); #2;
      if (reset || prob_ack) begin
        prob_ack = 1'b0; req_age = 0;
      end else if (prob_req) begin
        req_age++;
        if (req_age == 2) begin
          prob_answer = 4'($urandom_range(0, 9));
          gen_answer  = prob_answer;
          prob_ack    = 1'b1;
          req_age     = 0;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] score_enc(input int s);
`ifdef SCORE_BCD_EN
    return 8'((s / 10) * 16 + (s % 10));
`else
    return 8'(s);
`endif
  endfunction

  function automatic logic [3:0] wrong_key(input logic [3:0] a);
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(10, 15));
    return 4'((int'(a) + 1 + int'($urandom_range(0, 8))) % 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ss_pulse();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic wait_question();
    int n = 0;
    while (prob_req !== 1'b1 && n < 100) begin step(1); n++; end
    check("req_rise", prob_req, 1);
    n = 0;
    while (prob_req !== 1'b0 && n < 10) begin step(1); n++; end
    check("req_ack_drop", prob_req, 0);
  endtask

  task automatic wait_over();
    int n = 0;
    while (game_over !== 1'b1 && n < 40) begin step(1); n++; end
    check("game_over", game_over, 1);
    check("over_playing", playing, 0);
    check("over_life", life, 0);
    check("over_score_held", score, score_enc(m_score));
  endtask

  // Present one key; result must appear two cycles after the strobe.
  task automatic answer_q(input logic [3:0] k);
    logic [3:0] a;
    a = gen_answer;
    key_digit = k; key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
    check("latency_n1", {right, wrong}, 2'b00);
    step(1);
    if (k == a && k <= 4'd9) begin
      m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
      check("right", right, 1);
      check("not_wrong", wrong, 0);
    end else begin
      if (m_life > 0) m_life--;
      check("wrong", wrong, 1);
      check("not_right", right, 0);
    end
    check("life", life, m_life);
    check("score", score, score_enc(m_score));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_life"}, life, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_time"}, time_left, 0);
    check({tag, "_flags"}, {prob_req, right, wrong, game_over, playing, paused}, 6'b0);
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; key_valid = 1'b0; key_digit = '0; mode = 2'b00;
    m_life = 0; m_score = 0;
    step(3);
    check_reset_vals("reset");
    reset = 1'b0;
    step(1);

    // Normal game, correct answer, key ignored while feedback is shown
    mode = 2'b00;
    ss_pulse();
    m_life = 3; m_score = 0;
    check("start_life", life, 3);
    check("start_playing", playing, 1);
    wait_question();
    check("t_easy", time_left, 10);
    answer_q(gen_answer);
    key_digit = gen_answer; key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
    step(1);
    check("show_key_ignored", score, score_enc(m_score));

    // Wrong key, then a full timeout
    wait_question();
    answer_q(wrong_key(gen_answer));
    wait_question();
    step(50);  check("tl_mid", time_left, 5);
    step(49);  check("tl_last", time_left, 1);
    step(1);   check("tl_zero", time_left, 0);
    check("timeout_judging", wrong, 0);
    step(1);
    m_life--;
    check("timeout_wrong", wrong, 1);
    check("timeout_life", life, m_life);

    // Last life lost, game over, restart in sudden-death mode
    wait_question();
    answer_q(wrong_key(gen_answer));
    wait_over();
    ss_pulse();
    m_score = 0;
    check("over_to_idle", {game_over, playing}, 2'b00);
    check("idle_score", score, 0);
    step(1);
    mode = 2'b11;
    ss_pulse();
    m_life = 1;
    check("sudden_life", life, 1);
    wait_question();
    check("t_hard", time_left, 3);
    answer_q(wrong_key(gen_answer));
    wait_over();
    ss_pulse();
    m_score = 0;
    check("idle_again", {game_over, playing, score}, 10'b0);
    step(1);

    // Pause freezes the countdown and prescaler; mode change mid-game has no effect
    mode = 2'b01;
    ss_pulse();
    m_life = 3; m_score = 0;
    wait_question();
    check("t_norm", time_left, 6);
    mode = 2'b11;
    step(25);
    check("pre_pause_tl", time_left, 4);
    ss_pulse();
    check("paused", {paused, playing}, 2'b11);
    key_digit = gen_answer; key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
    step(200);
    check("pause_tl_frozen", time_left, 4);
    check("pause_still", paused, 1);
    check("pause_key_ignored", {right, wrong, score}, {2'b00, score_enc(0)});
    ss_pulse();
    check("resumed", paused, 0);
    step(3);
    check("resume_tl", time_left, 4);
    step(1);
    check("resume_prescaler", time_left, 3);
    answer_q(gen_answer);

    // Key on the same cycle as the final tick is judged as a key; reset during feedback
    wait_question();
    check("mode_latched", time_left, 6);
    step(59);
    answer_q(gen_answer);
    reset = 1'b1;
    step(1);
    check_reset_vals("midgame_reset");
    reset = 1'b0;
    m_life = 0; m_score = 0;
    key_digit = 4'd1; key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
    step(2);
    check("idle_key_ignored", {playing, score, life}, 12'b0);

    // Score saturation over many correct rounds
    mode = 2'b00;
    ss_pulse();
    m_life = 3; m_score = 0;
    for (int r = 0; r < SCORE_MAX + 4; r++) begin
      wait_question();
      answer_q(gen_answer);
    end
    check("score_saturated", score, score_enc(SCORE_MAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
